// File: rtl/obj_pkg.sv
// obj_pkg: shared types and constants for the lane-runner object scheduler.
//   - object type encodings and the packed object record
//   - field positions within a 16-bit object word
//   - DIST_FAR: distance reported when no object is queued
//   - game state enum
package obj_pkg;

  localparam int OBJ_W   = 16;
  localparam int LANE_HI = 15;
  localparam int LANE_LO = 14;
  localparam int TYPE_HI = 13;
  localparam int TYPE_LO = 12;
  localparam int GAP_W   = 12;

  localparam logic signed [11:0] DIST_FAR = 12'sh7FF;

  typedef enum logic [1:0] {
    OBJ_COIN = 2'b00,
    OBJ_TURN = 2'b01,
    OBJ_WALL = 2'b10
  } obj_type_e;

  typedef struct packed {
    logic [1:0]       lane;
    obj_type_e        otype;
    logic [GAP_W-1:0] gap;
  } obj_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

endpackage

// File: rtl/obj_fifo.sv
// obj_fifo: synchronous DEPTH x W FIFO holding queued objects.
// Ports:
//   clk, reset (async, active-low)
//   push, wdata  - enqueue; accepted when not full, or when full and
//                  a pop is accepted in the same cycle
//   pop          - dequeue; ignored when empty
//   flush        - synchronous clear, wins over push/pop
//   full, empty, count
//   head         - oldest entry, head_nxt - entry behind it (combinational)
module obj_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head,
  output logic [W-1:0]               head_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_nxt   = rd_ptr + 1'b1;
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_nxt];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/obj_scheduler.sv
// obj_scheduler: spawns LFSR-derived objects into a FIFO, scrolls the head
// object toward the player each tick, and tracks game state/score/speed.
// Ports:
//   clk, reset (async, active-low)
//   start, tick, pop, point, game_over - control strobes/levels
//   rd_obj, obj_distance, obj_valid     - head object to the handler
//   running, handler_reset              - state indications
//   score, speed                        - run statistics
//
// state | meaning
// IDLE  | after reset, waiting for start; handler held in reset
// RUN   | spawning, scrolling, popping, scoring
// OVER  | loss latched; everything frozen until start with game_over=0
module obj_scheduler
  import obj_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter int          MIN_GAP      = 64,
  parameter int          SPEED_MAX    = 4,
  parameter int          LEVEL_POINTS = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                tick,
  input  logic                pop,
  input  logic                point,
  input  logic                game_over,
  output logic [15:0]         rd_obj,
  output logic signed [11:0]  obj_distance,
  output logic                obj_valid,
  output logic                running,
  output logic                handler_reset,
  output logic [15:0]         score,
  output logic [2:0]          speed
);

  localparam int AW = $clog2(DEPTH);

  state_e            state;
  logic [15:0]       lfsr;
  logic signed [11:0] head_dist;
  logic              pop_guard;

  logic              f_full, f_empty;
  logic [AW:0]       f_count;
  logic [15:0]       f_head, f_head_nxt;

  obj_t              new_obj;
  obj_t              nxt_obj;
  logic              run_act, do_pop, do_push, do_scroll, start_run;
  logic              has_next;
  logic [GAP_W-1:0]  nxt_gap;
  logic [12:0]       reload_sum;
  logic [11:0]       reload_val, scroll_val, head_u;
  logic [15:0]       score_nxt;
  logic              lvl_up;
  logic              unused_nxt_bits;

  always_comb begin
    new_obj.lane  = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
    case (lfsr[4:2])
      3'd4, 3'd5: new_obj.otype = OBJ_WALL;
      3'd6:       new_obj.otype = OBJ_TURN;
      default:    new_obj.otype = OBJ_COIN;
    endcase
    new_obj.gap = GAP_W'(MIN_GAP) + {6'd0, lfsr[10:5]};
  end

  assign nxt_obj         = obj_t'(f_head_nxt);
  assign unused_nxt_bits = ^{nxt_obj.lane, nxt_obj.otype};

  // game_over in RUN suppresses every other RUN action that cycle.
  assign run_act   = (state == RUN) && !game_over;
  assign do_pop    = run_act && pop && !pop_guard && !f_empty;
  assign do_push   = run_act && tick && (!f_full || do_pop);
  assign do_scroll = run_act && tick && !f_empty && !do_pop;
  assign start_run = start && ((state == IDLE) || (state == OVER && !game_over));

  // An object pushed alongside the pop of the last entry becomes the next head.
  always_comb begin
    has_next = 1'b0;
    nxt_gap  = '0;
    if (f_count >= (AW+1)'(2)) begin
      has_next = 1'b1;
      nxt_gap  = nxt_obj.gap;
    end else if (do_push) begin
      has_next = 1'b1;
      nxt_gap  = new_obj.gap;
    end
  end

  assign head_u     = head_dist;
  assign reload_sum = {1'b0, head_u} + {1'b0, nxt_gap};
  assign reload_val = (reload_sum > 13'd2047) ? 12'h7FF : reload_sum[11:0];
  assign scroll_val = (head_u < {9'd0, speed}) ? 12'd0 : head_u - {9'd0, speed};

  assign score_nxt = (score == 16'hFFFF) ? score : score + 16'd1;
  assign lvl_up    = (score_nxt != 16'd0) &&
                     ((score_nxt % 16'(LEVEL_POINTS)) == 16'd0) &&
                     (speed < 3'(SPEED_MAX));

  obj_fifo #(.DEPTH(DEPTH), .W(OBJ_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .wdata    (new_obj),
    .pop      (do_pop),
    .flush    (start_run),
    .full     (f_full),
    .empty    (f_empty),
    .count    (f_count),
    .head     (f_head),
    .head_nxt (f_head_nxt)
  );

  assign obj_valid    = !f_empty;
  assign rd_obj       = f_empty ? 16'h0000 : f_head;
  assign obj_distance = f_empty ? DIST_FAR : head_dist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      head_dist     <= DIST_FAR;
      pop_guard     <= 1'b0;
      score         <= 16'd0;
      speed         <= 3'd1;
      running       <= 1'b0;
      handler_reset <= 1'b1;
    end else begin
      pop_guard <= do_pop;
      if (do_push) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      case (state)
        IDLE, OVER: begin
          if (start_run) begin
            state         <= RUN;
            running       <= 1'b1;
            handler_reset <= 1'b0;
            score         <= 16'd0;
            speed         <= 3'd1;
            head_dist     <= DIST_FAR;
          end
        end
        RUN: begin
          if (game_over) begin
            state         <= OVER;
            running       <= 1'b0;
            handler_reset <= 1'b1;
          end else begin
            if (do_pop)
              head_dist <= has_next ? signed'(reload_val) : DIST_FAR;
            else if (do_push && f_empty)
              head_dist <= signed'(new_obj.gap);
            else if (do_scroll)
              head_dist <= signed'(scroll_val);
            if (point) begin
              score <= score_nxt;
              if (lvl_up) speed <= speed + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_scheduler.sv
module tb_obj_scheduler;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               tick = 1'b0;
  logic               pop = 1'b0;
  logic               point = 1'b0;
  logic               game_over = 1'b0;
  logic [15:0]        rd_obj;
  logic signed [11:0] obj_distance;
  logic               obj_valid;
  logic               running;
  logic               handler_reset;
  logic [15:0]        score;
  logic [2:0]         speed;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_obj [16];

  obj_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .tick          (tick),
    .pop           (pop),
    .point         (point),
    .game_over     (game_over),
    .rd_obj        (rd_obj),
    .obj_distance  (obj_distance),
    .obj_valid     (obj_valid),
    .running       (running),
    .handler_reset (handler_reset),
    .score         (score),
    .speed         (speed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] obj_of(input logic [15:0] l);
    logic [1:0]  ln;
    logic [1:0]  ty;
    logic [11:0] gp;
    ln = (l[1:0] == 2'd3) ? 2'd1 : l[1:0];
    case (l[4:2])
      3'd4, 3'd5: ty = 2'b10;
      3'd6:       ty = 2'b01;
      default:    ty = 2'b00;
    endcase
    gp = 12'd64 + {6'd0, l[10:5]};
    return {ln, ty, gp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      exp_obj[i] = obj_of(l);
      l = lfsr_step(l);
    end

    // power-on reset
    #2 reset = 1'b0;
    #2;
    chk("rst_valid", 32'(obj_valid), 32'd0);
    chk("rst_dist", 32'(obj_distance), 32'd2047);
    chk("rst_obj", 32'(rd_obj), 32'h0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_hreset", 32'(handler_reset), 32'd1);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_speed", 32'(speed), 32'd1);
    #4 reset = 1'b1;
    cyc();
    chk("idle_running", 32'(running), 32'd0);

    // start run
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    chk("start_hreset", 32'(handler_reset), 32'd0);

    // first tick pushes into empty FIFO: head = seed object, no scroll
    tick = 1'b1;
    cyc();
    chk("obj0_hand", 32'(rd_obj), 32'h4067);
    chk("obj0_dist", 32'(obj_distance), 32'd103);
    cycn(7);
    chk("fill_count8", 32'(dut.u_fifo.count), 32'd8);
    chk("fill_dist", 32'(obj_distance), 32'd96);
    cyc();  // 9th tick: full, nothing pushed, scroll only
    chk("full_no_push", 32'(dut.u_fifo.count), 32'd8);
    chk("full_dist_gap0_m8", 32'(obj_distance), 32'd95);
    chk("obj0_model", 32'(rd_obj), 32'(exp_obj[0]));

    // pop + tick on full FIFO: reload wins, push still happens
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("poptick_count", 32'(dut.u_fifo.count), 32'd8);
    chk("poptick_dist", 32'(obj_distance), 32'd210);
    chk("poptick_obj1", 32'(rd_obj), 32'h2073);

    // three speed-1 ticks: 210 -> 207
    cycn(3);
    tick = 1'b0;
    chk("scroll_207", 32'(obj_distance), 32'd207);

    // scoring and speed levels
    point = 1'b1;
    cycn(7);
    chk("score7", 32'(score), 32'd7);
    chk("speed_at7", 32'(speed), 32'd1);
    cyc();
    chk("score8", 32'(score), 32'd8);
    chk("speed_at8", 32'(speed), 32'd2);
    cycn(24);
    chk("score32", 32'(score), 32'd32);
    chk("speed_at32", 32'(speed), 32'd4);
    cycn(8);
    point = 1'b0;
    chk("score40", 32'(score), 32'd40);
    chk("speed_at40", 32'(speed), 32'd4);

    // speed-4 scroll to 3, then saturate at 0
    tick = 1'b1;
    cycn(51);
    chk("dist3", 32'(obj_distance), 32'd3);
    cyc();
    chk("dist_sat0", 32'(obj_distance), 32'd0);
    cyc();
    tick = 1'b0;
    chk("dist_stay0", 32'(obj_distance), 32'd0);

    // pop held two cycles: exactly one dequeue
    pop = 1'b1;
    cycn(2);
    pop = 1'b0;
    chk("guard_count7", 32'(dut.u_fifo.count), 32'd7);
    chk("guard_dist_gap2", 32'(obj_distance), 32'(exp_obj[2][11:0]));
    chk("guard_obj2", 32'(rd_obj), 32'(exp_obj[2]));

    // game over, with competing RUN actions in the same cycle
    game_over = 1'b1;
    tick = 1'b1;
    pop = 1'b1;
    point = 1'b1;
    cyc();
    chk("over_running", 32'(running), 32'd0);
    chk("over_hreset", 32'(handler_reset), 32'd1);
    cycn(3);
    tick = 1'b0;
    pop = 1'b0;
    point = 1'b0;
    chk("over_score", 32'(score), 32'd40);
    chk("over_speed", 32'(speed), 32'd4);
    chk("over_count", 32'(dut.u_fifo.count), 32'd7);
    chk("over_dist", 32'(obj_distance), 32'(exp_obj[2][11:0]));
    start = 1'b1;
    cyc();
    chk("over_start_blocked", 32'(running), 32'd0);
    game_over = 1'b0;
    cyc();
    start = 1'b0;
    chk("rerun_running", 32'(running), 32'd1);
    chk("rerun_hreset", 32'(handler_reset), 32'd0);
    chk("rerun_score", 32'(score), 32'd0);
    chk("rerun_speed", 32'(speed), 32'd1);
    chk("rerun_valid", 32'(obj_valid), 32'd0);
    chk("rerun_dist", 32'(obj_distance), 32'd2047);

    // LFSR continues across runs
    tick = 1'b1;
    cyc();
    chk("rerun_obj9", 32'(rd_obj), 32'(exp_obj[9]));
    chk("rerun_dist9", 32'(obj_distance), 32'(exp_obj[9][11:0]));
    cycn(4);
    tick = 1'b0;
    chk("five_queued", 32'(dut.u_fifo.count), 32'd5);

    // asynchronous reset mid-run
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(obj_valid), 32'd0);
    chk("arst_dist", 32'(obj_distance), 32'd2047);
    chk("arst_obj", 32'(rd_obj), 32'h0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_hreset", 32'(handler_reset), 32'd1);
    #3 reset = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(running), 32'd0);
    chk("post_rst_valid", 32'(obj_valid), 32'd0);

    // LFSR reseeded by reset only
    start = 1'b1;
    cyc();
    start = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("reseed_obj0", 32'(rd_obj), 32'h4067);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
